countdown_timer: RTL and testbench

Loadable down-counter and timer, the counting-down counterpart to the team's free-running up counter. It accepts a start value over a valid/ready load handshake, then decrements on enabled ticks through an optional prescaler. At zero it flags expiry, either stopping (one-shot) or reloading (periodic). It is the timeout and interval source for control blocks in the same clock domain.

---
 rtl/countdown_timer.sv | 143 ++++++++++++++
 tb/tb_countdown_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter/timer: one-shot or periodic expiry after N prescaled ticks.
// Latency: accepted load visible on count the next cycle; each step visible the cycle after its edge.
// Backpressure: load_ready drops while RUN/PAUSED or during abort; the source holds load_valid until accepted.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_auto,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             tick_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  // Prescaler is at least one bit wide so PRESCALE=1 still elaborates cleanly.
  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             auto_q;
  logic [PW-1:0]    presc_q;
  logic             expired_q;
  logic             done_q;
  logic             busy_q;

  logic             load_acc;
  logic             presc_wrap;
  logic [PW-1:0]    presc_d;
  logic [WIDTH-1:0] count_dec_d;

  // Loads are only taken when the counter is not running; abort also blocks them.
  assign load_ready  = ((state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_DONE)) && !abort;
  assign load_acc    = load_valid && load_ready;
  assign presc_wrap  = (presc_q == PRESC_LAST);
  assign presc_d     = presc_wrap ? '0 : (presc_q + PW'(1));
  assign count_dec_d = count_q - WIDTH'(1);

  assign count   = count_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign done    = done_q;

  // Control FSM: priority abort > load > pause > start > step, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      auto_q    <= 1'b0;
      presc_q   <= '0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // expired is a single-cycle pulse unless re-raised below.
      expired_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        count_q <= '0;
        presc_q <= '0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (load_acc) begin
        state_q  <= S_ARMED;
        count_q  <= load_value;
        reload_q <= load_value;
        auto_q   <= load_auto;
        presc_q  <= '0;
        done_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_ARMED: begin
            if (start) begin
              if (count_q != '0) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
              end else begin
                // Zero load expires immediately rather than running.
                state_q   <= S_DONE;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (pause) begin
              state_q <= S_PAUSED;
            end else if (tick_en) begin
              presc_q <= presc_d;
              if (presc_wrap) begin
                if (count_q > WIDTH'(1)) begin
                  count_q <= count_dec_d;
                end else if (auto_q && (reload_q != '0)) begin
                  count_q   <= reload_q;
                  expired_q <= 1'b1;
                end else begin
                  count_q   <= '0;
                  expired_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                end
              end
            end
          end
          S_PAUSED: begin
            // Prescaler phase is kept so a resume continues mid-period.
            if (start) begin
              state_q <= S_RUN;
            end
          end
          S_IDLE, S_DONE: begin
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table through a scoreboard queue on a PRESCALE=1 instance,
// hand sequences for async reset and for a PRESCALE=4 instance sharing the same inputs.
// Checks sampled 1 time unit after the rising edge; inputs driven on the falling edge.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_value;
  logic       load_auto;
  logic       start;
  logic       pause;
  logic       abort;
  logic       tick_en;

  logic       rdy1, busy1, exp1, done1;
  logic [7:0] cnt1;
  logic       rdy4, busy4, exp4, done4;
  logic [7:0] cnt4;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       lv;
    logic [7:0] lval;
    logic       la;
    logic       st;
    logic       ps;
    logic       ab;
    logic       tk;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_exp;
    logic       e_done;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy1),
    .load_value(load_value), .load_auto(load_auto), .start(start), .pause(pause),
    .abort(abort), .tick_en(tick_en), .count(cnt1), .busy(busy1),
    .expired(exp1), .done(done1)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy4),
    .load_value(load_value), .load_auto(load_auto), .start(start), .pause(pause),
    .abort(abort), .tick_en(tick_en), .count(cnt4), .busy(busy4),
    .expired(exp4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(input logic lv, input logic [7:0] lval, input logic la,
                             input logic st, input logic ps, input logic ab, input logic tk,
                             input logic [7:0] ec, input logic eb, input logic ee,
                             input logic ed, input logic er);
    vec_t v;
    v.lv = lv; v.lval = lval; v.la = la; v.st = st; v.ps = ps; v.ab = ab; v.tk = tk;
    v.e_cnt = ec; v.e_busy = eb; v.e_exp = ee; v.e_done = ed; v.e_rdy = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    load_valid = v.lv; load_value = v.lval; load_auto = v.la;
    start = v.st; pause = v.ps; abort = v.ab; tick_en = v.tk;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".count"},   32'(cnt1),  32'(e.e_cnt));
    chk({tag, ".busy"},    32'(busy1), 32'(e.e_busy));
    chk({tag, ".expired"}, 32'(exp1),  32'(e.e_exp));
    chk({tag, ".done"},    32'(done1), 32'(e.e_done));
    chk({tag, ".ready"},   32'(rdy1),  32'(e.e_rdy));
  endtask

  // Runs the PRESCALE=4 instance from just after its start edge; tick_en is low on edges g_lo..g_hi.
  task automatic run_prescaled(input int g_lo, input int g_hi, output int at);
    at = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start   = 1'b0;
      tick_en = (n >= g_lo && n <= g_hi) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (g_lo == 0 && n == 3) chk("presc.count_before_step", 32'(cnt4), 32'd2);
      if (g_lo == 0 && n == 4) chk("presc.count_first_step",  32'(cnt4), 32'd1);
      if (exp4) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic load_and_start4(input logic [7:0] val);
    @(negedge clk);
    load_valid = 1'b1; load_value = val; load_auto = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0; tick_en = 1'b1;
    @(posedge clk);
    #1;
    chk("presc.load_count", 32'(cnt4), 32'(val));
    @(negedge clk);
    load_valid = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    chk("presc.start_busy", 32'(busy4), 32'd1);
  endtask

  initial begin
    int at;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    load_valid = 1'b0; load_value = 8'd0; load_auto = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0; tick_en = 1'b0;

    // lv lval la st ps ab tk  ->  count busy expired done ready
    // one-shot 3
    vecs.push_back(V(1,  3, 0, 0, 0, 0, 1,  3, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 1,  3, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  2, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 1));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1));
    // periodic 2, then abort
    vecs.push_back(V(1,  2, 1, 0, 0, 0, 1,  2, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 1,  2, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  2, 1, 1, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  2, 1, 1, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
    // pause / resume
    vecs.push_back(V(1, 10, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 0, 10, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  9, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  7, 1, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(V(0, 0, 0, 0, 1, 0, 1,  7, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 1,  7, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  6, 1, 0, 0, 0));
    // boundaries: load while running, zero load, load+start, auto with zero, idle start
    vecs.push_back(V(1, 50, 0, 0, 0, 0, 0,  6, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(V(1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 1));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1));
    vecs.push_back(V(1,  9, 0, 1, 0, 0, 0,  9, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 0,  9, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(V(1,  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 1,  0, 0, 1, 1, 1));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1));
    vecs.push_back(V(0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1));
    // periodic reload 1: expiry every cycle
    vecs.push_back(V(1,  1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    // lead-in to async reset: count reaches 3 while running
    vecs.push_back(V(1,  5, 0, 0, 0, 0, 0,  5, 0, 0, 0, 1));
    vecs.push_back(V(0,  0, 0, 1, 0, 0, 0,  5, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  4, 1, 0, 0, 0));
    vecs.push_back(V(0,  0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0));

    // Reset state, observed before any clock edge.
    #2;
    chk("reset.count",   32'(cnt1),  32'd0);
    chk("reset.busy",    32'(busy1), 32'd0);
    chk("reset.expired", 32'(exp1),  32'd0);
    chk("reset.done",    32'(done1), 32'd0);
    chk("reset.ready",   32'(rdy1),  32'd1);
    chk("reset.ready4",  32'(rdy4),  32'd1);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply_vec(vecs[i], $sformatf("v%0d", i));

    // Async reset between edges while running at count 3.
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset.count",   32'(cnt1),  32'd0);
    chk("areset.busy",    32'(busy1), 32'd0);
    chk("areset.done",    32'(done1), 32'd0);
    chk("areset.expired", 32'(exp1),  32'd0);
    chk("areset.ready",   32'(rdy1),  32'd1);
    #1;
    rst_n = 1'b1;
    apply_vec(V(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1), "post_reset.start_ignored");
    apply_vec(V(1, 4, 0, 0, 0, 0, 0,  4, 0, 0, 0, 1), "post_reset.load");
    apply_vec(V(0, 0, 0, 1, 0, 0, 1,  4, 1, 0, 0, 0), "post_reset.start");
    apply_vec(V(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0), "post_reset.abort");

    // Prescaler 4: load 2 expires on the 8th ticking edge after start.
    load_and_start4(8'd2);
    run_prescaled(0, -1, at);
    chk("presc.expire_edge", 32'(at), 32'd8);
    chk("presc.done",        32'(done4), 32'd1);
    chk("presc.count_zero",  32'(cnt4),  32'd0);

    // Same run with tick_en low on edges 3..5: expiry moves out by exactly 3.
    load_and_start4(8'd2);
    run_prescaled(3, 5, at);
    chk("presc.gated_expire_edge", 32'(at), 32'd11);
    chk("presc.gated_busy",        32'(busy4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
